// File: rtl/polygraph_session_ctrl.sv
// Polygraph session sequencer: settles, collects sensor samples per question,
// counts detector alarms and reports a per-question verdict.
module polygraph_session_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SAMPLES       = 4,
    parameter int unsigned THRESH        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  num_q,
    input  logic [9:0]  age,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [9:0]  s_bloodP,
    input  logic [9:0]  s_breathR,
    input  logic [9:0]  s_heartB,
    output logic [9:0]  det_bloodP,
    output logic [9:0]  det_breathR,
    output logic [9:0]  det_heartB,
    output logic [9:0]  det_age,
    input  logic        det_alarm,
    output logic        q_valid,
    output logic [3:0]  q_index,
    output logic        q_lie,
    output logic [3:0]  q_alarm_cnt,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CW = 4;
    localparam int unsigned QW = 4;
    localparam int unsigned DW = 10;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, SAMPLE, WAIT1, WAIT2, REPORT, FINISH
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [CW-1:0]   samp_cnt;
    logic [CW-1:0]   alarm_cnt;
    logic [QW-1:0]   num_q_lat;
    logic [QW-1:0]   q_idx;

    logic            start_ok;
    logic            abort_now;
    logic            hs;
    logic            settle_done;
    logic            samp_last;
    logic            last_q;

    assign start_ok    = start && (num_q != '0);
    assign abort_now   = abort && (state != IDLE);
    assign hs          = (state == SAMPLE) && s_valid;
    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign samp_last   = (CW'(samp_cnt + CW'(1)) == CW'(SAMPLES));
    assign last_q      = (q_idx == QW'(num_q_lat - QW'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = SAMPLE;
            SAMPLE:  if (hs) state_nxt = WAIT1;
            WAIT1:   state_nxt = WAIT2;
            WAIT2:   state_nxt = samp_last ? REPORT : SAMPLE;
            REPORT:  state_nxt = last_q ? FINISH : SETTLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_now) state_nxt = IDLE;
    end

    // State-decoded outputs
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        q_valid = 1'b0;
        done    = 1'b0;
        q_lie   = 1'b0;
        s_ready = (state == SAMPLE);
        busy    = (state != IDLE);
        q_valid = (state == REPORT);
        done    = (state == FINISH);
        q_lie   = (state == REPORT) && (alarm_cnt >= CW'(THRESH));
    end

    assign q_alarm_cnt = alarm_cnt;
    assign q_index     = q_idx;

    // Session datapath: counters, latched config and detector drive; frozen on abort
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt  <= '0;
            samp_cnt    <= '0;
            alarm_cnt   <= '0;
            num_q_lat   <= '0;
            q_idx       <= '0;
            det_bloodP  <= '0;
            det_breathR <= '0;
            det_heartB  <= '0;
            det_age     <= '0;
        end else if (!abort_now) begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        num_q_lat  <= num_q;
                        det_age    <= age;
                        q_idx      <= '0;
                        alarm_cnt  <= '0;
                        samp_cnt   <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: settle_cnt <= SW'(settle_cnt + SW'(1));
                SAMPLE: begin
                    if (hs) begin
                        det_bloodP  <= DW'(s_bloodP);
                        det_breathR <= DW'(s_breathR);
                        det_heartB  <= DW'(s_heartB);
                    end
                end
                WAIT2: begin
                    samp_cnt <= CW'(samp_cnt + CW'(1));
                    if (det_alarm && (alarm_cnt != CNT_MAX))
                        alarm_cnt <= CW'(alarm_cnt + CW'(1));
                end
                REPORT: begin
                    if (!last_q) begin
                        q_idx      <= QW'(q_idx + QW'(1));
                        alarm_cnt  <= '0;
                        samp_cnt   <= '0;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polygraph_session_ctrl.sv
// Directed bench for polygraph_session_ctrl; a registered detector model
// flags an alarm whenever det_bloodP >= 512.
module tb_polygraph_session_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, s_valid;
    logic [3:0] num_q;
    logic [9:0] age, s_bloodP, s_breathR, s_heartB;

    logic       a_s_ready, a_q_valid, a_q_lie, a_busy, a_done;
    logic [3:0] a_q_index, a_q_alarm_cnt;
    logic [9:0] a_det_bloodP, a_det_breathR, a_det_heartB, a_det_age;
    logic       a_det_alarm = 1'b0;

    logic       b_s_ready, b_q_valid, b_q_lie, b_busy, b_done;
    logic [3:0] b_q_index, b_q_alarm_cnt;
    logic [9:0] b_det_bloodP, b_det_breathR, b_det_heartB, b_det_age;
    logic       b_det_alarm = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_det_alarm <= a_det_bloodP[9];
        b_det_alarm <= b_det_bloodP[9];
    end

    polygraph_session_ctrl #(.SETTLE_CYCLES(8), .SAMPLES(4), .THRESH(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_q(num_q), .age(age),
        .s_valid(s_valid), .s_ready(a_s_ready),
        .s_bloodP(s_bloodP), .s_breathR(s_breathR), .s_heartB(s_heartB),
        .det_bloodP(a_det_bloodP), .det_breathR(a_det_breathR), .det_heartB(a_det_heartB),
        .det_age(a_det_age), .det_alarm(a_det_alarm),
        .q_valid(a_q_valid), .q_index(a_q_index), .q_lie(a_q_lie),
        .q_alarm_cnt(a_q_alarm_cnt), .busy(a_busy), .done(a_done)
    );

    polygraph_session_ctrl #(.SETTLE_CYCLES(8), .SAMPLES(15), .THRESH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_q(num_q), .age(age),
        .s_valid(s_valid), .s_ready(b_s_ready),
        .s_bloodP(s_bloodP), .s_breathR(s_breathR), .s_heartB(s_heartB),
        .det_bloodP(b_det_bloodP), .det_breathR(b_det_breathR), .det_heartB(b_det_heartB),
        .det_age(b_det_age), .det_alarm(b_det_alarm),
        .q_valid(b_q_valid), .q_index(b_q_index), .q_lie(b_q_lie),
        .q_alarm_cnt(b_q_alarm_cnt), .busy(b_busy), .done(b_done)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return a_s_ready;
            1:       return a_q_valid;
            2:       return a_done;
            3:       return b_q_valid;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait: returns immediately if the condition already holds
    task automatic wait_for(input int sel, input int max, input string tag);
        int n = 0;
        while (!cond(sel) && n < max) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(cond(sel)), 32'd1);
    endtask

    task automatic feed(input logic [9:0] bp, input string tag);
        wait_for(0, 50, tag);
        s_bloodP  = bp;
        s_breathR = 10'd30;
        s_heartB  = 10'd70;
        tick();
        check({tag, "_det_bp"}, 32'(a_det_bloodP), 32'(bp));
        check({tag, "_ready_low"}, 32'(a_s_ready), 32'd0);
    endtask

    initial begin
        int nv, nd, vcount;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        num_q = 4'd0; age = 10'd0;
        s_bloodP = 10'd0; s_breathR = 10'd0; s_heartB = 10'd0;
        tick(); tick();
        check("rst_busy", 32'(a_busy), 0);
        check("rst_ready", 32'(a_s_ready), 0);
        check("rst_qvalid", 32'(a_q_valid), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_qidx", 32'(a_q_index), 0);
        check("rst_acnt", 32'(a_q_alarm_cnt), 0);
        check("rst_lie", 32'(a_q_lie), 0);
        check("rst_det", 32'({a_det_bloodP, a_det_breathR, a_det_heartB}), 0);
        check("rst_age", 32'(a_det_age), 0);
        rst = 1'b0;
        tick();

        // Single question, alarms on samples 1 and 3
        start = 1'b1; num_q = 4'd1; age = 10'd25; s_valid = 1'b1;
        tick();
        start = 1'b0;
        check("q1_busy", 32'(a_busy), 1);
        check("q1_age", 32'(a_det_age), 25);
        age = 10'd99; num_q = 4'd7;
        repeat (7) tick();
        check("q1_ready_before", 32'(a_s_ready), 0);
        tick();
        check("q1_ready_at8", 32'(a_s_ready), 1);
        feed(10'd600, "q1_s1");
        feed(10'd100, "q1_s2");
        feed(10'd700, "q1_s3");
        feed(10'd50,  "q1_s4");
        tick();
        check("q1_wait2_noqv", 32'(a_q_valid), 0);
        tick();
        check("q1_qvalid", 32'(a_q_valid), 1);
        check("q1_acnt", 32'(a_q_alarm_cnt), 2);
        check("q1_lie", 32'(a_q_lie), 1);
        check("q1_qidx", 32'(a_q_index), 0);
        check("q1_age_held", 32'(a_det_age), 25);
        check("q1_done_early", 32'(a_done), 0);
        tick();
        check("q1_done", 32'(a_done), 1);
        check("q1_qv_drop", 32'(a_q_valid), 0);
        tick();
        check("q1_idle", 32'(a_busy), 0);
        check("q1_done_drop", 32'(a_done), 0);

        // Three questions, no alarms, s_valid held; start mid-session is ignored
        start = 1'b1; num_q = 4'd3; s_bloodP = 10'd100;
        tick();
        start = 1'b0;
        nv = 0; nd = 0;
        for (int c = 0; c < 80; c++) begin
            if (c == 30) begin start = 1'b1; num_q = 4'd1; end
            if (c == 31) start = 1'b0;
            if (a_q_valid) begin
                check("q3_idx", 32'(a_q_index), 32'(nv));
                check("q3_lie", 32'(a_q_lie), 0);
                check("q3_cycle", 32'(c), 32'(20 + 21 * nv));
                nv++;
            end
            if (a_done) nd++;
            tick();
        end
        check("q3_nvalid", 32'(nv), 3);
        check("q3_ndone", 32'(nd), 1);
        check("q3_idle", 32'(a_busy), 0);

        // s_valid withheld for 20 cycles in SAMPLE
        s_valid = 1'b0; start = 1'b1; num_q = 4'd1;
        tick();
        start = 1'b0;
        s_bloodP = 10'd777;
        wait_for(0, 50, "stall_rdy");
        repeat (20) tick();
        check("stall_ready", 32'(a_s_ready), 1);
        check("stall_det_hold", 32'(a_det_bloodP), 100);
        s_valid = 1'b1;
        tick();
        check("stall_hs", 32'(a_det_bloodP), 777);
        check("stall_wait1", 32'(a_s_ready), 0);
        wait_for(1, 60, "stall_qv");
        check("stall_acnt", 32'(a_q_alarm_cnt), 4);
        wait_for(2, 5, "stall_done");
        tick();

        // Abort in WAIT1 of question index 1
        s_bloodP = 10'd100; start = 1'b1; num_q = 4'd2;
        tick();
        start = 1'b0;
        wait_for(1, 40, "ab_qv0");
        check("ab_qidx0", 32'(a_q_index), 0);
        tick();
        wait_for(0, 20, "ab_rdy1");
        tick();
        check("ab_wait1_idx", 32'(a_q_index), 1);
        check("ab_wait1_busy", 32'(a_busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(a_busy), 0);
        check("ab_ready", 32'(a_s_ready), 0);
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            if (a_q_valid || a_done) vcount++;
            tick();
        end
        check("ab_no_strobes", 32'(vcount), 0);
        start = 1'b1; num_q = 4'd1;
        tick();
        start = 1'b0;
        wait_for(1, 40, "ab_restart_qv");
        check("ab_restart_idx", 32'(a_q_index), 0);
        check("ab_restart_acnt", 32'(a_q_alarm_cnt), 0);
        wait_for(2, 5, "ab_restart_done");
        tick();

        // Reset in REPORT; reset beats start and abort
        s_bloodP = 10'd600; start = 1'b1; num_q = 4'd1;
        tick();
        start = 1'b0;
        wait_for(1, 40, "rr_qv");
        check("rr_acnt_pre", 32'(a_q_alarm_cnt), 4);
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0;
        check("rr_qv", 32'(a_q_valid), 0);
        check("rr_busy", 32'(a_busy), 0);
        tick();
        check("rr_start_blocked", 32'(a_busy), 0);
        rst = 1'b0; start = 1'b1; num_q = 4'd0;
        check("rr_acnt", 32'(a_q_alarm_cnt), 0);
        check("rr_lie", 32'(a_q_lie), 0);
        check("rr_det", 32'({a_det_bloodP, a_det_age}), 0);
        check("rr_done", 32'(a_done), 0);
        tick();
        start = 1'b0;
        tick();
        check("rr_numq0_idle", 32'(a_busy), 0);
        check("rr_numq0_idle_b", 32'(b_busy), 0);

        // SAMPLES=15, every sample alarms
        start = 1'b1; num_q = 4'd1;
        tick();
        start = 1'b0;
        wait_for(3, 80, "sat_qv");
        check("sat_acnt", 32'(b_q_alarm_cnt), 15);
        check("sat_lie", 32'(b_q_lie), 1);
        tick();
        check("sat_done", 32'(b_done), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/polygraph_session_ctrl.md
POLYGRAPH_SESSION_CTRL -- requirements
Module: polygraph_session_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- SETTLE_CYCLES, 8: idle cycles before sampling each question.
- SAMPLES, 4: sensor samples evaluated per question, range 1..15.
- THRESH, 2: alarm count at or above which a question is flagged a lie, range 1..15.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on posedge.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: begin session, honoured only in IDLE.
- abort, in, 1: cancel session.
- num_q, in, 4: number of questions, sampled at start.
- age, in, 10: subject age, latched at start.
- s_valid, in, 1: sensor sample valid.
- s_ready, out, 1: controller accepts sample.
- s_bloodP, s_breathR, s_heartB, in, 10 each: sensor sample.
- det_bloodP, det_breathR, det_heartB, det_age, out, 10 each: registered drive to the detector.
- det_alarm, in, 1: detector alarm flag; det_BP, det_BR and det_HB are ignored.
- q_valid, out, 1: one-cycle per-question result strobe.
- q_index, out, 4: current question number, 0-based.
- q_lie, out, 1: verdict, qualified by q_valid.
- q_alarm_cnt, out, 4: alarms counted for the question, qualified by q_valid.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at normal session end.

Function
REQ-003 States are IDLE, SETTLE, SAMPLE, WAIT1, WAIT2, REPORT, FINISH, encoded as a registered one-hot or binary state register.
REQ-004 IDLE to SETTLE occurs on start=1 with num_q!=0.
- On that transition: latch num_q, latch age onto det_age, clear q_index, alarm counter and sample counter.
- start=1 with num_q=0 is ignored and the block stays in IDLE.
REQ-005 SETTLE lasts exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
REQ-006 s_ready=1 only in SAMPLE.
- A handshake occurs when s_valid and s_ready are both 1 on a clock edge.
- On a handshake: register the sample onto det_bloodP/breathR/heartB and go to WAIT1.
- Without a handshake the block stays in SAMPLE with no timeout.
REQ-007 WAIT1 and WAIT2 each last one cycle, covering the detector's one-cycle registered latency.
- At the end of WAIT2, det_alarm is sampled.
- If det_alarm=1, the alarm counter increments, saturating at 15.
- The sample counter increments.
REQ-008 After WAIT2:
- If the sample counter equals SAMPLES, go to REPORT.
- Otherwise go to SAMPLE.
REQ-009 REPORT lasts one cycle with q_valid=1.
- q_alarm_cnt = alarm counter.
- q_lie = (alarm counter >= THRESH).
- q_index holds the current question.
REQ-010 After REPORT:
- If q_index == num_q-1, go to FINISH.
- Otherwise increment q_index, clear the alarm and sample counters, and go to SETTLE.
REQ-011 FINISH lasts one cycle with done=1, then goes to IDLE.
REQ-012 abort=1 in any state other than IDLE forces IDLE on the next edge.
- No q_valid and no done are produced.
- abort has priority over every other transition, including REPORT and FINISH.
REQ-013 start is ignored while busy=1.
- num_q and age changes after start have no effect until the next session.
REQ-014 det_* outputs hold their last value outside handshakes; no glitching between samples.
REQ-015 Counters: SETTLE counter is clog2(SETTLE_CYCLES+1) bits; alarm and sample counters are 4 bits.

Reset
REQ-016 rst=1 on an edge forces IDLE, including mid-session. All outputs then take these values:
- s_ready=0, q_valid=0, q_lie=0, q_alarm_cnt=0, q_index=0, busy=0, done=0.
- All det_* = 0.
- All counters are cleared.
REQ-017 rst has priority over abort and start.

Verification
REQ-018 num_q=1, age=25, SETTLE_CYCLES=8, SAMPLES=4, THRESH=2, detector alarms on samples 1 and 3.
- s_ready rises 8 cycles after start.
- One q_valid with q_alarm_cnt=2 and q_lie=1.
- done pulses one cycle after q_valid.
REQ-019 num_q=3, no alarms, s_valid held high.
- q_valid asserts three times with q_index 0, 1, 2, each with q_lie=0.
- Each question takes 8+4*3+1 = 21 cycles.
- Exactly one done pulse.
REQ-020 s_valid withheld for 20 cycles in SAMPLE.
- State stays SAMPLE and det_* hold.
- When s_valid rises, the handshake completes on that edge.
REQ-021 abort asserted during WAIT1 of question 1.
- IDLE on the next edge, busy=0, no q_valid and no done.
- A new start works normally.
REQ-022 rst asserted in REPORT.
- q_valid=0 on the next cycle and all outputs at reset values.
- start=1 with num_q=0 afterwards leaves busy=0.
REQ-023 All alarms with SAMPLES=15.
- q_alarm_cnt=15, saturated, and q_lie=1.
